pwm_generator: RTL and testbench
================================

Name: pwm_generator

Overview:
- Responder end of the angle-to-PWM ratio handshake: accepts `pwm_ratio`/`pwm_direction` requests, applies them only at PWM period boundaries, and reports absorption on `pwm_done` (one rising edge per applied period).
- Drives the motor driver's PWM and direction pins for one swerve rotation motor.
- Free-running 255-step period, prescaled from the main clock.

Parameters:
- PRESCALE, 4, clock cycles per PWM count step (≥1).
- DEADTIME_PERIODS, 2, whole PWM periods of forced-low output on a direction reversal (used only with DIR_DEADTIME_EN).

Ports:
- clock  input  1  main clock, all logic on posedge
- reset_n  input  1  synchronous active-low reset (sampled on posedge clock)
- pwm_enable  input  1  run enable; low forces output off
- pwm_update  input  1  level request: while high, new ratio/direction sampled at each period boundary
- pwm_ratio  input  8  requested high-time out of 255
- pwm_direction  input  1  requested motor direction
- pwm_done  output  1  absorption indicator; rises once per period in which a requested value was loaded
- pwm_out  output  1  PWM waveform to driver
- dir_out  output  1  applied direction to driver
- active_ratio  output  8  ratio currently in effect (debug)

Behaviour:
- Reset (reset_n low at posedge): state OFF, pwm_out=0, dir_out=0, pwm_done=0, active_ratio=0, prescaler=0, count=0.
- Prescaler: 0..PRESCALE-1. `tick` is high when the prescaler equals PRESCALE-1. `count` (8 bit) advances on tick, 0..254, then wraps to 0.
- Boundary: the cycle where tick=1 and count=254.
- Output: pwm_out = (state==RUN) & (count < active_ratio), registered.
  - ratio 0 → constant low.
  - ratio 255 → constant high (255 > any count).
- States:
  - OFF:
    - count, prescaler, active_ratio held 0; pwm_out=0; pwm_done=0.
    - pwm_enable=1 → RUN on the next cycle; the first period starts at count 0.
    - The first load occurs at the first boundary.
  - RUN:
    - At a boundary with pwm_update=1: active_ratio←pwm_ratio and dir_out←pwm_direction; the new values are in effect from count 0 of the next period.
    - The same applies with DIR_DEADTIME_EN undefined. With it defined, see Optional Feature.
    - At a boundary with pwm_update=0: active_ratio unchanged.
  - DEADTIME: defined under Optional Feature.
- pwm_done timing, per boundary with pwm_update=1:
  - pwm_done←0 on the tick where count=253, if pwm_update=1 at that tick.
  - pwm_done←1 on the boundary cycle when the load happens.
  - This guarantees ≥PRESCALE low cycles, so the requester's edge detector sees exactly one rising edge per load.
- pwm_update=0: pwm_done holds its value (no new edges).
- pwm_update rising mid-period: the first load is at the next boundary; no partial-period load.
- pwm_ratio changing mid-period: ignored until the boundary; the sampled value is the one present on the boundary cycle.
- pwm_enable falling in any state: → OFF next cycle; pwm_out=0 that cycle; pwm_done=0; active_ratio=0; dir_out retained.
- reset_n low mid-period: all values return to reset values on that edge, regardless of state.
- Simultaneous pwm_enable fall and boundary: disable wins; no load, no done edge.

Optional Feature:
- Macro DIR_DEADTIME_EN.
- Defined:
  - At a boundary with pwm_update=1 and pwm_direction≠dir_out: go to DEADTIME, with active_ratio←0 and pwm_out=0.
  - dir_out and pwm_done unchanged at that boundary.
  - DEADTIME counts DEADTIME_PERIODS boundaries. At the last one: dir_out←pwm_direction, active_ratio←pwm_ratio, pwm_done rises (normal low/high rule applies), → RUN.
  - Same direction: behaves as RUN.
  - pwm_enable low in DEADTIME → OFF.
- Undefined: no DEADTIME state; the direction changes at the boundary with the load.

Test Plan:
- PRESCALE=1, enable, pwm_update=1, ratio=64 → from the first load, each 255-cycle period has pwm_out high for exactly 64 cycles and low for 191. pwm_done rises once per period, on the boundary cycle.
- ratio 0 then 255 → first full period constant low. After the next boundary, constant high for a full period. active_ratio reads 0x00 then 0xFF.
- pwm_update=1, ratio changed 32→200 at count 100 → rest of the period uses 32; the next period has 200 high cycles. Exactly one pwm_done rising edge per boundary.
- pwm_update=0 for 3 periods → pwm_done constant, active_ratio unchanged. Re-assert → first edge at the next boundary.
- Direction 0→1 with DIR_DEADTIME_EN, DEADTIME_PERIODS=2 → 2 periods with pwm_out=0 and dir_out=0. Then dir_out=1, ratio applied, one pwm_done edge. Without the macro: dir_out=1 at the first boundary.
- pwm_enable or reset_n low at count 120, ratio 200 → pwm_out=0 next cycle, pwm_done=0, active_ratio=0. Re-enable → period restarts at count 0.

Source files
------------

// File: rtl/pwm_generator_if.sv
// Ratio/direction request handshake between the angle controller and the PWM generator.
interface pwm_generator_if;
    logic       pwm_update;
    logic [7:0] pwm_ratio;
    logic       pwm_direction;
    logic       pwm_done;

    modport master (
        output pwm_update,
        output pwm_ratio,
        output pwm_direction,
        input  pwm_done
    );

    modport slave (
        input  pwm_update,
        input  pwm_ratio,
        input  pwm_direction,
        output pwm_done
    );
endinterface

// File: rtl/pwm_generator.sv
// 255-step prescaled PWM generator for one swerve rotation motor.
// Optional DIR_DEADTIME_EN inserts forced-low periods on a direction reversal.
module pwm_generator #(
    parameter int PRESCALE         = 4,
    parameter int DEADTIME_PERIODS = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             pwm_enable,
    pwm_generator_if.slave   req,
    output logic             pwm_out,
    output logic             dir_out,
    output logic [7:0]       active_ratio
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_RUN,
        ST_DEAD
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_n;
    logic [7:0]    count;
    logic [7:0]    count_n;
    logic [7:0]    ratio_n;
    logic          dir_n;
    logic          done_n;
    logic          out_n;
    logic          done_q;
    logic          tick;
    logic          boundary;
    logic          pre_edge;

`ifdef DIR_DEADTIME_EN
    localparam int DW = (DEADTIME_PERIODS > 1) ? $clog2(DEADTIME_PERIODS) : 1;
    logic [DW-1:0] dt_cnt;
    logic [DW-1:0] dt_n;
`endif

    assign tick     = (presc == PW'(PRESCALE - 1));
    assign boundary = tick && (count == 8'd254);
    assign pre_edge = tick && (count == 8'd253);
    assign req.pwm_done = done_q;

    always_comb begin
        state_n = state;
        presc_n = presc;
        count_n = count;
        ratio_n = active_ratio;
        dir_n   = dir_out;
        done_n  = done_q;
`ifdef DIR_DEADTIME_EN
        dt_n    = dt_cnt;
`endif
        if (!pwm_enable) begin
            state_n = ST_OFF;
            presc_n = '0;
            count_n = '0;
            ratio_n = '0;
            done_n  = 1'b0;
        end else begin
            case (state)
                ST_OFF: begin
                    state_n = ST_RUN;
                    presc_n = '0;
                    count_n = '0;
                    ratio_n = '0;
                    done_n  = 1'b0;
                end
                ST_RUN: begin
                    presc_n = tick ? '0 : presc + PW'(1);
                    if (tick)
                        count_n = boundary ? 8'd0 : count + 8'd1;
                    // Drop done one count early so every load gives a fresh edge
                    if (pre_edge && req.pwm_update)
                        done_n = 1'b0;
                    if (boundary && req.pwm_update) begin
`ifdef DIR_DEADTIME_EN
                        if (req.pwm_direction != dir_out) begin
                            state_n = ST_DEAD;
                            ratio_n = '0;
                            dt_n    = '0;
                        end else begin
                            ratio_n = req.pwm_ratio;
                            dir_n   = req.pwm_direction;
                            done_n  = 1'b1;
                        end
`else
                        ratio_n = req.pwm_ratio;
                        dir_n   = req.pwm_direction;
                        done_n  = 1'b1;
`endif
                    end
                end
`ifdef DIR_DEADTIME_EN
                ST_DEAD: begin
                    presc_n = tick ? '0 : presc + PW'(1);
                    if (tick)
                        count_n = boundary ? 8'd0 : count + 8'd1;
                    if (pre_edge && req.pwm_update)
                        done_n = 1'b0;
                    if (boundary) begin
                        if (dt_cnt == DW'(DEADTIME_PERIODS - 1)) begin
                            state_n = ST_RUN;
                            ratio_n = req.pwm_ratio;
                            dir_n   = req.pwm_direction;
                            done_n  = 1'b1;
                        end else begin
                            dt_n = dt_cnt + DW'(1);
                        end
                    end
                end
`endif
                default: begin
                    state_n = ST_OFF;
                    presc_n = '0;
                    count_n = '0;
                    ratio_n = '0;
                    done_n  = 1'b0;
                end
            endcase
        end
        // Output register tracks the count it will sit beside
        out_n = (state_n == ST_RUN) && (count_n < ratio_n);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= ST_OFF;
            presc        <= '0;
            count        <= '0;
            active_ratio <= '0;
            dir_out      <= 1'b0;
            done_q       <= 1'b0;
            pwm_out      <= 1'b0;
        end else begin
            state        <= state_n;
            presc        <= presc_n;
            count        <= count_n;
            active_ratio <= ratio_n;
            dir_out      <= dir_n;
            done_q       <= done_n;
            pwm_out      <= out_n;
        end
    end

`ifdef DIR_DEADTIME_EN
    always_ff @(posedge clock) begin
        if (!reset_n)
            dt_cnt <= '0;
        else
            dt_cnt <= dt_n;
    end
`endif

endmodule

// File: tb/tb_pwm_generator.sv
// Self-checking bench for pwm_generator: period-phase reference model plus directed and random stimulus.
module tb_pwm_generator;

    localparam int P   = 2;
    localparam int DTP = 2;
    localparam int PER = 255 * P;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       pwm_enable = 1'b0;
    logic       pwm_out;
    logic       dir_out;
    logic [7:0] active_ratio;

    pwm_generator_if bus();

    pwm_generator #(
        .PRESCALE(P),
        .DEADTIME_PERIODS(DTP)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .pwm_enable(pwm_enable),
        .req(bus.slave),
        .pwm_out(pwm_out),
        .dir_out(dir_out),
        .active_ratio(active_ratio)
    );

    always #5 clock = ~clock;

    // model: mode 0 off, 1 run, 2 deadtime; m_p = phase in clocks within period
    int   m_mode = 0;
    int   m_p = 0;
    int   m_ratio = 0;
    int   m_dir = 0;
    int   m_done = 0;
    int   m_dtl = 0;
    int   nbound = 0;
    bit   bflag;
    int   cur_high = 0;
    int   last_high = 0;
    int   cur_rises = 0;
    int   last_rises = 0;
    logic prev_done = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   exp_out;

    always @(posedge clock) begin
        bflag = 1'b0;
        if (!reset_n) begin
            m_mode = 0; m_p = 0; m_ratio = 0; m_dir = 0; m_done = 0;
        end else if (!pwm_enable) begin
            m_mode = 0; m_p = 0; m_ratio = 0; m_done = 0;
        end else if (m_mode == 0) begin
            m_mode = 1; m_p = 0;
        end else begin
            if (m_p == 254 * P - 1 && bus.pwm_update)
                m_done = 0;
            if (m_p == PER - 1) begin
                bflag = 1'b1;
                nbound++;
                if (m_mode == 2) begin
                    m_dtl--;
                    if (m_dtl == 0) begin
                        m_ratio = bus.pwm_ratio;
                        m_dir = bus.pwm_direction;
                        m_done = 1;
                        m_mode = 1;
                    end
                end else if (bus.pwm_update) begin
`ifdef DIR_DEADTIME_EN
                    if (int'(bus.pwm_direction) != m_dir) begin
                        m_mode = 2; m_dtl = DTP; m_ratio = 0;
                    end else begin
                        m_ratio = bus.pwm_ratio; m_dir = bus.pwm_direction; m_done = 1;
                    end
`else
                    m_ratio = bus.pwm_ratio; m_dir = bus.pwm_direction; m_done = 1;
`endif
                end
                m_p = 0;
            end else begin
                m_p++;
            end
        end
        #1;
        exp_out = (m_mode == 1) && ((m_p / P) < m_ratio);
        checks++;
        if (pwm_out !== exp_out || dir_out !== m_dir[0] ||
            bus.pwm_done !== m_done[0] || int'(active_ratio) != m_ratio) begin
            errors++;
            $display("FAIL cycle t=%0t pwm_out %b exp %b dir_out %b exp %0d done %b exp %0d ratio %0d exp %0d",
                     $time, pwm_out, exp_out, dir_out, m_dir, bus.pwm_done, m_done, active_ratio, m_ratio);
        end
        if (bflag) begin
            last_high = cur_high; cur_high = 0;
            last_rises = cur_rises; cur_rises = 0;
        end
        if (pwm_out === 1'b1) cur_high++;
        if (bus.pwm_done === 1'b1 && prev_done !== 1'b1) cur_rises++;
        prev_done = bus.pwm_done;
    end

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic wait_bounds(input int n);
        int target;
        bit ok;
        target = nbound + n;
        ok = 1'b0;
        for (int i = 0; i < (n + 4) * PER * (DTP + 1); i++) begin
            @(negedge clock);
            if (nbound >= target) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("boundary_timeout", nbound, target);
    endtask

    task automatic wait_phase(input int ph);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3 * PER; i++) begin
            @(negedge clock);
            if (m_mode == 1 && m_p == ph) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("phase_timeout", m_p, ph);
    endtask

    initial begin
        bus.pwm_update = 1'b0;
        bus.pwm_ratio = 8'd0;
        bus.pwm_direction = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_out", int'(pwm_out), 0);
        chk("reset_dir", int'(dir_out), 0);
        chk("reset_done", int'(bus.pwm_done), 0);
        chk("reset_ratio", int'(active_ratio), 0);
        reset_n = 1'b1;

        // steady ratio 64
        pwm_enable = 1'b1;
        bus.pwm_update = 1'b1;
        bus.pwm_ratio = 8'd64;
        wait_bounds(2);
        chk("r64_high", last_high, 64 * P);
        chk("r64_rises", last_rises, 1);
        chk("r64_ratio", int'(active_ratio), 64);
        chk("r64_model", m_ratio, 64);
        chk("r64_done", int'(bus.pwm_done), 1);

        // extremes
        bus.pwm_ratio = 8'd0;
        wait_bounds(2);
        chk("r0_high", last_high, 0);
        chk("r0_ratio", int'(active_ratio), 0);
        bus.pwm_ratio = 8'd255;
        wait_bounds(2);
        chk("r255_high", last_high, PER);
        chk("r255_ratio", int'(active_ratio), 255);

        // mid-period ratio change
        bus.pwm_ratio = 8'd32;
        wait_bounds(1);
        wait_phase(100 * P);
        bus.pwm_ratio = 8'd200;
        wait_bounds(1);
        chk("mid_high32", last_high, 32 * P);
        chk("mid_rises", last_rises, 1);
        wait_bounds(1);
        chk("mid_high200", last_high, 200 * P);
        chk("mid_rises2", last_rises, 1);

        // update held low
        bus.pwm_update = 1'b0;
        bus.pwm_ratio = 8'd10;
        wait_bounds(3);
        chk("hold_ratio", int'(active_ratio), 200);
        chk("hold_done", int'(bus.pwm_done), 1);
        chk("hold_rises", last_rises, 0);
        bus.pwm_update = 1'b1;
        wait_bounds(1);
        chk("reassert_ratio", int'(active_ratio), 10);
        wait_bounds(1);
        chk("reassert_rises", last_rises, 1);

        // direction reversal
        bus.pwm_direction = 1'b1;
        bus.pwm_ratio = 8'd50;
`ifdef DIR_DEADTIME_EN
        wait_bounds(1);
        chk("dt_dir0", int'(dir_out), 0);
        chk("dt_ratio0", int'(active_ratio), 0);
        wait_bounds(1);
        chk("dt_high0", last_high, 0);
        wait_bounds(1);
        chk("dt_high1", last_high, 0);
        chk("dt_dir1", int'(dir_out), 1);
        chk("dt_ratio", int'(active_ratio), 50);
        chk("dt_done", int'(bus.pwm_done), 1);
`else
        wait_bounds(1);
        chk("dir_now", int'(dir_out), 1);
        chk("dir_ratio", int'(active_ratio), 50);
`endif

        // disable mid-period
        bus.pwm_ratio = 8'd200;
        wait_bounds(2);
        wait_phase(120 * P);
        pwm_enable = 1'b0;
        @(negedge clock);
        chk("dis_out", int'(pwm_out), 0);
        chk("dis_done", int'(bus.pwm_done), 0);
        chk("dis_ratio", int'(active_ratio), 0);
        chk("dis_dir", int'(dir_out), 1);
        repeat (5) @(negedge clock);
        pwm_enable = 1'b1;
        wait_bounds(2);
        chk("reen_high", last_high, 200 * P);

        // reset mid-period
        wait_phase(120 * P);
        reset_n = 1'b0;
        bus.pwm_direction = 1'b0;
        @(negedge clock);
        chk("rst_out", int'(pwm_out), 0);
        chk("rst_done", int'(bus.pwm_done), 0);
        chk("rst_ratio", int'(active_ratio), 0);
        chk("rst_dir", int'(dir_out), 0);
        reset_n = 1'b1;
        wait_bounds(2);
        chk("rst_high", last_high, 200 * P);

        // random traffic against the model
        for (int it = 0; it < 40; it++) begin
            repeat ($urandom_range(1, 700)) @(negedge clock);
            bus.pwm_ratio = 8'($urandom);
            bus.pwm_update = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) bus.pwm_direction = ~bus.pwm_direction;
            pwm_enable = ($urandom_range(0, 15) != 0);
            reset_n = ($urandom_range(0, 19) != 0);
        end
        repeat (10) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
